multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multicycle main-control FSM for the MiniMIPS datapath. Sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch/decode/execute/memory/write-back states, with a ready handshake toward unified memory.
- Each cycle it drives the 3-bit ALUOp consumed by ALUcontrol, plus all datapath enables and mux selects.

Parameters:
- WAIT_LIMIT, 0, maximum cycles spent waiting on mem_ready in one memory access. 0 = unlimited; otherwise 1..255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  4  IR[15:12]; valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- ALUOp  output  3  operation class to ALUcontrol
- alu_src_a  output  1  0=PC, 1=rs
- alu_src_b  output  2  00=rt, 01=constant 1, 10=sign-extended imm, 11=zero-extended imm
- pc_we  output  1  PC write enable
- pc_src  output  2  00=ALU result, 01=branch target, 10=jump target
- ir_we  output  1  instruction register write enable
- mem_rd  output  1  memory read request
- mem_wr  output  1  memory write request
- reg_we  output  1  register file write enable
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALU result, 1=memory data
- halted  output  1  core stopped
- illegal_op  output  1  one-cycle pulse on undefined opcode
- mem_timeout  output  1  sticky wait-limit violation flag

Behaviour:
- Reset (asynchronous, active-high):
  - state=FETCH, op_q=0, wait counter=0, mem_timeout=0.
  - All outputs are 0 while reset is high.
- Outputs are combinational from state, op_q and the inputs. Every output not listed for a state is 0.
- Opcode map:
  - 0000 R-type
  - 0001 ADDI, 0010 ANDI, 0011 ORI, 0100 SLTI
  - 0101 LW, 0110 SW
  - 0111 BEQ, 1000 BNE
  - 1001 J
  - 1111 HALT
  - all other codes are illegal
- FETCH(000):
  - Drives mem_rd=1, ALUOp=010, alu_src_a=0, alu_src_b=01.
  - When mem_ready=1: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE(001):
  - op_q<=opcode.
  - R-type/imm -> EXEC; LW/SW -> EXEC; BEQ/BNE -> BRANCH; J -> JUMP; HALT -> HALT.
  - Illegal opcode: illegal_op=1 for this cycle, then go to FETCH.
- EXEC(010):
  - ALUOp: R=000, ADDI/LW/SW=010, ANDI=100, ORI=110, SLTI=101.
  - alu_src_a=1.
  - alu_src_b: R=00, ANDI/ORI=11, others=10.
  - Next state: LW/SW -> MEM, else -> WB.
- MEM(011):
  - LW drives mem_rd=1; SW drives mem_wr=1. ALUOp=010 is held.
  - On mem_ready: LW -> WB, SW -> FETCH.
- WB(100):
  - reg_we=1.
  - reg_dst=1 for R-type only; mem_to_reg=1 for LW only.
  - ALUOp/alu_src held as in EXEC.
  - Next state: FETCH.
- BRANCH(101):
  - ALUOp=001, alu_src_a=1, alu_src_b=00, pc_src=01.
  - pc_we=zero for BEQ, pc_we=~zero for BNE.
  - Next state: FETCH.
- JUMP(110): pc_src=10, pc_we=1, then FETCH.
- HALT(111): halted=1; remains until reset.
- Latency with zero-wait memory (mem_ready=1 in the same cycle as the request):
  - R/imm: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE/J: 3 cycles.
- Wait counter:
  - 8-bit; counts consecutive cycles in FETCH/MEM with the request high and mem_ready=0.
  - Clears when mem_ready=1 or on any state change.
  - If WAIT_LIMIT!=0 and the count reaches WAIT_LIMIT: set mem_timeout=1 and go to HALT. Requests drop that cycle.
  - mem_timeout clears only on reset.
- mem_ready is ignored outside FETCH/MEM. zero is ignored outside BRANCH.
- Reset asserted mid-instruction aborts it immediately; no partial write enables are generated afterward.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - Adds output instr_retired (16 bits).
  - Increments on every transition into FETCH from WB, MEM(SW), BRANCH or JUMP. Illegal-opcode returns do not count.
  - Wraps 0xFFFF->0x0000. Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset high mid-EXEC of ADDI, then release -> all outputs 0 during reset. First cycle after release: state FETCH, mem_rd=1, ALUOp=010.
- R-type opcode 0000, mem_ready=1 throughout -> FETCH, DECODE, EXEC(ALUOp=000, alu_src_b=00), WB(reg_we=1, reg_dst=1). Next FETCH at cycle 5.
- LW opcode 0101, mem_ready held 0 for 3 cycles in MEM -> mem_rd=1 for 4 MEM cycles, then WB with mem_to_reg=1, reg_we=1.
- BEQ 0111 with zero=1, then BNE 1000 with zero=1 -> BEQ BRANCH cycle: pc_we=1, pc_src=01, ALUOp=001. BNE BRANCH cycle: pc_we=0.
- Opcode 1010, then 1111 -> illegal_op pulses exactly 1 cycle in DECODE, then FETCH. HALT: halted=1 stays high for 20 cycles with no enables.
- WAIT_LIMIT=4, mem_ready=0 forever in FETCH -> mem_timeout=1 after the 4th wait cycle, then HALT. With CTRL_PERF_CNT_EN, instr_retired stays 0.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main-control FSM for the MiniMIPS multicycle datapath. Each instruction
// walks FETCH -> DECODE -> (EXEC -> [MEM] -> WB | BRANCH | JUMP | HALT) and
// returns to FETCH. Every cycle it drives the 3-bit ALUOp class consumed by
// ALUcontrol plus all datapath enables and mux selects. Memory accesses in
// FETCH/MEM complete on mem_ready; an optional wait limit turns a stalled
// access into a sticky mem_timeout and a transition to HALT.
//
// Parameters:
//   WAIT_LIMIT   max consecutive wait cycles per access (0 = unlimited, 1..255)
//
// Optional feature (macro CTRL_PERF_CNT_EN):
//   adds output instr_retired[15:0], a wrapping count of completed
//   instructions (returns to FETCH from WB, MEM(SW), BRANCH or JUMP).
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   opcode[3:0]           IR[15:12], sampled in DECODE
//   zero                  ALU zero flag, used only in BRANCH
//   mem_ready             memory completes the access this cycle
//   ALUOp[2:0]            operation class for ALUcontrol
//   alu_src_a, alu_src_b  ALU operand selects
//   pc_we, pc_src         PC write enable / source select
//   ir_we                 instruction register write enable
//   mem_rd, mem_wr        memory requests
//   reg_we, reg_dst       register file write enable / destination select
//   mem_to_reg            write-back data select
//   halted                core stopped
//   illegal_op            one-cycle pulse on undefined opcode in DECODE
//   mem_timeout           sticky wait-limit violation flag
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned WAIT_LIMIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  ALUOp,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        halted,
  output logic        illegal_op,
`ifdef CTRL_PERF_CNT_EN
  output logic [15:0] instr_retired,
`endif
  output logic        mem_timeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_BRANCH = 3'b101,
    S_JUMP   = 3'b110,
    S_HALT   = 3'b111
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SLTI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic       LIMIT_EN = (WAIT_LIMIT != 32'd0);
  localparam logic [7:0] LIMIT    = WAIT_LIMIT[7:0];

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] op_r;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_s;
  logic       timeout_hit_s;

  // ALUOp class used in EXEC and held through WB.
  function automatic logic [2:0] exec_alu_op(input logic [3:0] op);
    case (op)
      OP_R:    return 3'b000;
      OP_ANDI: return 3'b100;
      OP_ORI:  return 3'b110;
      OP_SLTI: return 3'b101;
      default: return 3'b010;  // ADDI, LW, SW: add
    endcase
  endfunction

  // Second ALU operand select used in EXEC and held through WB.
  function automatic logic [1:0] exec_src_b(input logic [3:0] op);
    case (op)
      OP_R:            return 2'b00;
      OP_ANDI, OP_ORI: return 2'b11;  // logical immediates are zero-extended
      default:         return 2'b10;
    endcase
  endfunction

  // The wait limit fires in the cycle after the count has reached it.
  assign timeout_hit_s = LIMIT_EN && (wait_cnt_r == LIMIT) &&
                         ((state_r == S_FETCH) || (state_r == S_MEM));

  // Next-state and datapath control decode; everything is forced low in reset.
  always_comb begin
    next_state_s = state_r;
    ALUOp        = 3'b000;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    ir_we        = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    halted       = 1'b0;
    illegal_op   = 1'b0;
    if (reset) begin
      next_state_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          ALUOp     = 3'b010;
          alu_src_b = 2'b01;
          if (timeout_hit_s) begin
            next_state_s = S_HALT;
          end else begin
            mem_rd = 1'b1;
            if (mem_ready) begin
              ir_we        = 1'b1;
              pc_we        = 1'b1;
              next_state_s = S_DECODE;
            end else begin
              next_state_s = S_FETCH;
            end
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW:
                          next_state_s = S_EXEC;
            OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
            OP_J:           next_state_s = S_JUMP;
            OP_HALT:        next_state_s = S_HALT;
            default: begin
              illegal_op   = 1'b1;
              next_state_s = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          ALUOp     = exec_alu_op(op_r);
          alu_src_a = 1'b1;
          alu_src_b = exec_src_b(op_r);
          if ((op_r == OP_LW) || (op_r == OP_SW)) begin
            next_state_s = S_MEM;
          end else begin
            next_state_s = S_WB;
          end
        end
        S_MEM: begin
          ALUOp = 3'b010;
          if (timeout_hit_s) begin
            next_state_s = S_HALT;
          end else begin
            if (op_r == OP_LW) begin
              mem_rd = 1'b1;
            end else begin
              mem_wr = 1'b1;
            end
            if (mem_ready) begin
              next_state_s = (op_r == OP_LW) ? S_WB : S_FETCH;
            end else begin
              next_state_s = S_MEM;
            end
          end
        end
        S_WB: begin
          ALUOp        = exec_alu_op(op_r);
          alu_src_a    = 1'b1;
          alu_src_b    = exec_src_b(op_r);
          reg_we       = 1'b1;
          reg_dst      = (op_r == OP_R);
          mem_to_reg   = (op_r == OP_LW);
          next_state_s = S_FETCH;
        end
        S_BRANCH: begin
          ALUOp        = 3'b001;
          alu_src_a    = 1'b1;
          pc_src       = 2'b01;
          pc_we        = (op_r == OP_BNE) ? ~zero : zero;
          next_state_s = S_FETCH;
        end
        S_JUMP: begin
          pc_src       = 2'b10;
          pc_we        = 1'b1;
          next_state_s = S_FETCH;
        end
        S_HALT: begin
          halted       = 1'b1;
          next_state_s = S_HALT;
        end
        default: begin
          next_state_s = S_FETCH;
        end
      endcase
    end
  end

  // Consecutive wait cycles of the current access; saturates at 255.
  always_comb begin
    wait_cnt_s = 8'd0;
    if (((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready && !timeout_hit_s) begin
      if (wait_cnt_r != 8'hFF) begin
        wait_cnt_s = wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_s = wait_cnt_r;
      end
    end else begin
      wait_cnt_s = 8'd0;
    end
  end

  // State, latched opcode, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_FETCH;
      op_r        <= 4'b0000;
      wait_cnt_r  <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_s;
      if (state_r == S_DECODE) begin
        op_r <= opcode;
      end else begin
        op_r <= op_r;
      end
      // Flag is raised as the count reaches the limit; the access is
      // abandoned in the following cycle.
      if (LIMIT_EN && (wait_cnt_s == LIMIT)) begin
        mem_timeout <= 1'b1;
      end else begin
        mem_timeout <= mem_timeout;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic retire_s;

  // MEM returns straight to FETCH only for SW; illegal opcodes leave from DECODE.
  assign retire_s = (next_state_s == S_FETCH) &&
                    ((state_r == S_WB) || (state_r == S_MEM) ||
                     (state_r == S_BRANCH) || (state_r == S_JUMP));

  // Retired-instruction counter, wraps at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_retired <= 16'd0;
    end else if (retire_s) begin
      instr_retired <= instr_retired + 16'd1;
    end else begin
      instr_retired <= instr_retired;
    end
  end
`endif

endmodule
